// File: rtl/bus_mem_slave.sv
// ---------------------------------------------------------------------------
// bus_mem_slave
//
// A word-organised memory slave for the CPU's Avalon-style bus. CPU byte
// addresses starting at BASE_ADDR map onto an array of 32-bit words. Writes
// honour per-byte enables. Read data is registered and is valid the cycle
// after the read is accepted. Every transaction is stalled for exactly
// WAIT_STATES cycles using waitrequest, so the CPU's stall handling gets
// exercised.
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   reset_n      asynchronous active-low reset (the memory array is kept)
//   address      CPU byte address
//   read/write   request strobes; held by the CPU while waitrequest is high
//   waitrequest  combinational stall, derived from state and request
//   writedata    write data
//   byteenable   bit i enables writedata[8i+7:8i] onto byte i
//   readdata     registered read data; holds until the next accepted read
//   init_we      backdoor preload strobe; works in any state
//   init_index   backdoor word index
//   init_data    backdoor word data
//   bus_error    sticky error flag for range, alignment and protocol
//                errors; only reset clears it
// ---------------------------------------------------------------------------
module bus_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_STATES = 2,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   address,
  input  logic          write,
  input  logic          read,
  output logic          waitrequest,
  input  logic [31:0]   writedata,
  input  logic [3:0]    byteenable,
  output logic [31:0]   readdata,
  input  logic          init_we,
  input  logic [AW-1:0] init_index,
  input  logic [31:0]   init_data,
  output logic          bus_error
);

  typedef enum logic [1:0] {IDLE, STALL, ACCESS} state_e;

  localparam logic [3:0] WS4     = 4'(WAIT_STATES);
  localparam bit         NO_WAIT = (WAIT_STATES == 0);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] readdata_q;
  logic        bus_error_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          req;
  logic          accept;
  logic [31:0]   offset;
  logic [31:0]   word_off;
  logic [AW-1:0] idx;
  logic          is_zero;
  logic          addr_ok;
  logic          rd_acc;
  logic          wr_acc;
  logic          mem_we;
  logic          err_set;

  assign req = read | write;

  // The slave is ready only in ACCESS. With no wait states it is also ready
  // in IDLE, so a request is accepted on the first edge it is seen.
  assign waitrequest = req && !(state_q == ACCESS || (state_q == IDLE && NO_WAIT));
  assign accept      = req && !waitrequest;

  // Address decode. The subtraction wraps for addresses below BASE_ADDR,
  // which yields a huge word offset and so correctly fails the range test.
  assign offset   = address - BASE_ADDR;
  assign word_off = offset >> 2;
  assign idx      = word_off[AW-1:0];
  assign is_zero  = (address == 32'd0);
  assign addr_ok  = (word_off < 32'(DEPTH_WORDS)) && (address[1:0] == 2'b00) && !is_zero;

  // When read and write are both high, the handshake still completes, but
  // the transfer is rejected and only raises the error flag.
  assign rd_acc = accept && read && !write;
  assign wr_acc = accept && write && !read;
  // While reset is held, no bus write reaches the array, even in the
  // zero-wait configuration.
  assign mem_we = wr_acc && addr_ok && reset_n;
  // A read from address 0 is a harmless null read. A write to address 0 is
  // an error.
  assign err_set = accept && ((read && write) ||
                              (rd_acc && !is_zero && !addr_ok) ||
                              (wr_acc && !addr_ok));

  // Wait-state sequencer. cnt counts the stall cycles already spent. The
  // IDLE cycle that first sees the request is stall cycle 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req && !NO_WAIT) begin
          cnt_d   = 4'd1;
          state_d = (WS4 == 4'd1) ? ACCESS : STALL;
        end
      end
      STALL: begin
        if (!req) begin
          // The master withdrew the request, so abandon the transaction.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == WS4) state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      readdata_q  <= 32'd0;
      bus_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (rd_acc) readdata_q <= addr_ok ? mem[idx] : 32'd0;
      if (err_set) bus_error_q <= 1'b1;
    end
  end

  // Memory array, with no reset. The backdoor write is issued first, so
  // that a bus write to the same word on the same edge overrides only the
  // bytes the bus has enabled.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (init_we) mem[init_index][8*b +: 8] <= init_data[8*b +: 8];
      if (mem_we && byteenable[b]) mem[idx][8*b +: 8] <= writedata[8*b +: 8];
    end
  end

  assign readdata  = readdata_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_bus_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_bus_mem_slave
//
// Three slaves with WAIT_STATES = 2, 0 and 3 share the address, data and
// backdoor signals. Each slave has its own read and write strobes.
//
// A reference model predicts waitrequest, readdata and bus_error for every
// slave from the transaction rules alone:
//   - the number of cycles the request has been held so far;
//   - a word array and the decode rules.
// A single negedge process compares every slave against the model. The
// directed sequence then pins the model with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_bus_mem_slave;

  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int          DEPTH = 64;
  localparam int          NI    = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic        init_we = 1'b0;
  logic [5:0]  init_index = '0;
  logic [31:0] init_data = '0;

  logic [NI-1:0]       rd_s = '0;
  logic [NI-1:0]       wr_s = '0;
  logic [NI-1:0]       wrq;
  logic [NI-1:0]       berr;
  logic [NI-1:0][31:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    bus_mem_slave #(
      .BASE_ADDR  (BASE),
      .DEPTH_WORDS(DEPTH),
      .WAIT_STATES(gi == 0 ? 2 : (gi == 1 ? 0 : 3))
    ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .write      (wr_s[gi]),
      .read       (rd_s[gi]),
      .waitrequest(wrq[gi]),
      .writedata  (writedata),
      .byteenable (byteenable),
      .readdata   (rdata[gi]),
      .init_we    (init_we),
      .init_index (init_index),
      .init_data  (init_data),
      .bus_error  (berr[gi])
    );
  end

  // ---------------- reference model ----------------
  int          ws_m  [NI] = '{2, 0, 3};
  int          held_m[NI];
  logic [31:0] mem_m [NI][DEPTH];
  logic [31:0] rd_m  [NI];
  logic        err_m [NI];

  task automatic model_access(input int k);
    logic [31:0] off;
    bit          ok;
    int          w;
    off = address - BASE;
    w   = int'(off >> 2);
    ok  = (address != 0) && (address[1:0] == 2'b00) && ((off >> 2) < 32'(DEPTH));
    if (rd_s[k] && wr_s[k]) begin
      err_m[k] = 1'b1;
    end else if (rd_s[k]) begin
      if (address == 0) rd_m[k] = 32'd0;
      else if (!ok) begin rd_m[k] = 32'd0; err_m[k] = 1'b1; end
      else rd_m[k] = mem_m[k][w];
    end else begin
      if (!ok) err_m[k] = 1'b1;
      else
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) mem_m[k][w][8*b +: 8] = writedata[8*b +: 8];
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NI; k++) begin
        held_m[k] = 0; rd_m[k] = 32'd0; err_m[k] = 1'b0;
      end
    end else begin
      if (init_we)
        for (int k = 0; k < NI; k++) mem_m[k][init_index] = init_data;
      for (int k = 0; k < NI; k++) begin
        if (!(rd_s[k] || wr_s[k])) held_m[k] = 0;
        else if (held_m[k] < ws_m[k]) held_m[k]++;
        else begin
          held_m[k] = 0;
          model_access(k);
        end
      end
    end
  end

  // A single compare process, sampled on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      logic exp_w;
      exp_w = (rd_s[k] || wr_s[k]) && (held_m[k] < ws_m[k]);
      checks++;
      if (wrq[k] !== exp_w) begin
        errors++;
        $display("FAIL waitrequest[%0d] t=%0t got %b expected %b", k, $time, wrq[k], exp_w);
      end
      checks++;
      if (rdata[k] !== rd_m[k]) begin
        errors++;
        $display("FAIL readdata[%0d] t=%0t got %h expected %h", k, $time, rdata[k], rd_m[k]);
      end
      checks++;
      if (berr[k] !== err_m[k]) begin
        errors++;
        $display("FAIL bus_error[%0d] t=%0t got %b expected %b", k, $time, berr[k], err_m[k]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    @(posedge clk); #1;
    init_we = 1'b1; init_index = 6'(idx); init_data = d;
    @(posedge clk); #1;
    init_we = 1'b0;
  endtask

  task automatic bus(input int k, input bit r, input bit w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be, output int nwait);
    @(posedge clk); #1;
    address = a; writedata = wd; byteenable = be;
    rd_s[k] = r; wr_s[k] = w;
    nwait = 0;
    @(negedge clk);
    while (wrq[k] && nwait < 40) begin
      nwait++;
      @(negedge clk);
    end
    if (wrq[k]) begin
      checks++; errors++;
      $display("FAIL handshake timeout inst %0d addr %h", k, a);
    end
    @(posedge clk); #1;
    rd_s[k] = 1'b0; wr_s[k] = 1'b0;
    $display("txn inst=%0d rd=%0b wr=%0b addr=%h wd=%h be=%b waits=%0d rdata=%h err=%b",
             k, r, w, a, wd, be, nwait, rdata[k], berr[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("reset readdata0", rdata[0], 32'h0);
    chk("reset bus_error", 32'(berr), 32'h0);
    chk("reset waitrequest", 32'(wrq), 32'h0);

    preload(0, 32'h0000_0000);
    preload(1, 32'h8D09_0030);
    preload(3, 32'h1122_3344);
    preload(5, 32'h55AA_55AA);
    preload(12, 32'hBFC0_0018);

    // Read with two wait states.
    bus(0, 1, 0, BASE + 32'h4, '0, '0, nw);
    chk("ws2 wait count", 32'(nw), 32'd2);
    chk("ws2 readdata", rdata[0], 32'h8D09_0030);
    chk("ws2 bus_error", 32'(berr[0]), 32'h0);

    // Zero wait states, then a null read from address 0.
    bus(1, 1, 0, BASE + 32'h30, '0, '0, nw);
    chk("ws0 wait count", 32'(nw), 32'd0);
    chk("ws0 readdata", rdata[1], 32'hBFC0_0018);
    bus(1, 1, 0, 32'h0, '0, '0, nw);
    chk("addr0 readdata", rdata[1], 32'h0);
    chk("addr0 bus_error", 32'(berr[1]), 32'h0);

    // Byte-enabled write, then a write with all byte enables off.
    bus(0, 0, 1, BASE + 32'hC, 32'hAABB_CCDD, 4'b0101, nw);
    bus(0, 1, 0, BASE + 32'hC, '0, '0, nw);
    chk("be0101 readback", rdata[0], 32'h11BB_33DD);
    bus(0, 0, 1, BASE + 32'hC, 32'hFFFF_FFFF, 4'b0000, nw);
    bus(0, 1, 0, BASE + 32'hC, '0, '0, nw);
    chk("be0000 readback", rdata[0], 32'h11BB_33DD);
    chk("be0000 bus_error", 32'(berr[0]), 32'h0);

    // Reset pulsed in the second stall cycle of a held write.
    @(posedge clk); #1;
    address = BASE + 32'h14; writedata = 32'hDEAD_BEEF; byteenable = 4'hF; wr_s[2] = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0; wr_s[2] = 1'b0;
    #1;
    chk("abort waitrequest", 32'(wrq[2]), 32'h0);
    chk("abort readdata0", rdata[0], 32'h0);
    chk("abort bus_error", 32'(berr), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus(2, 1, 0, BASE + 32'h14, '0, '0, nw);
    chk("abort word unchanged", rdata[2], 32'h55AA_55AA);
    chk("ws3 read waits", 32'(nw), 32'd3);
    bus(2, 0, 1, BASE + 32'h14, 32'hDEAD_BEEF, 4'hF, nw);
    chk("ws3 write waits", 32'(nw), 32'd3);
    bus(2, 1, 0, BASE + 32'h14, '0, '0, nw);
    chk("ws3 write commit", rdata[2], 32'hDEAD_BEEF);

    // Out-of-range read, then a misaligned out-of-range write.
    bus(0, 1, 0, BASE + 32'h4, '0, '0, nw);
    bus(0, 1, 0, BASE + 32'h100, '0, '0, nw);
    chk("oor readdata", rdata[0], 32'h0);
    chk("oor bus_error", 32'(berr[0]), 32'h1);
    bus(0, 0, 1, BASE + 32'h102, 32'h1234_5678, 4'hF, nw);
    chk("oor sticky", 32'(berr[0]), 32'h1);
    bus(0, 1, 0, BASE, '0, '0, nw);
    chk("oor word0 intact", rdata[0], 32'h0);
    chk("oor sticky after good read", 32'(berr[0]), 32'h1);
    bus(0, 1, 0, BASE + 32'h4, '0, '0, nw);
    chk("oor word1 intact", rdata[0], 32'h8D09_0030);

    // Read and write both high at a valid address.
    bus(1, 1, 0, BASE + 32'h30, '0, '0, nw);
    bus(1, 1, 1, BASE + 32'h30, 32'h0, 4'hF, nw);
    chk("both readdata held", rdata[1], 32'hBFC0_0018);
    chk("both bus_error", 32'(berr[1]), 32'h1);
    bus(1, 1, 0, BASE + 32'h30, '0, '0, nw);
    chk("both memory intact", rdata[1], 32'hBFC0_0018);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_mem_slave.md
Name: bus_mem_slave

Overview:
- Synthesizable word-organised memory slave on the CPU's Avalon-style data/instruction bus. It sits directly downstream of mips_cpu_bus and replaces ad-hoc bench memories.
- Maps CPU byte addresses starting at the reset vector onto a word array.
- Applies per-byte write enables and returns read data one cycle after acceptance.
- Inserts a programmable number of wait states via waitrequest, so CPU stall handling is exercised.

Parameters:
- BASE_ADDR, 32'hBFC00000, byte address of word 0.
- DEPTH_WORDS, 64, number of 32-bit words (power of two, 4..1024).
- WAIT_STATES, 2, cycles waitrequest is held high per transaction (0..15).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- address  input  32  byte address from CPU
- write  input  1  write request
- read  input  1  read request
- waitrequest  output  1  stall; CPU must hold request and all inputs while high
- writedata  input  32  write data
- byteenable  input  4  bit i enables writedata[8i+7:8i] onto byte i
- readdata  output  32  read data, valid the cycle after read acceptance
- init_we  input  1  backdoor preload strobe
- init_index  input  clog2(DEPTH_WORDS)  backdoor word index
- init_data  input  32  backdoor word data
- bus_error  output  1  sticky protocol/range error flag

Behaviour:
- Reset (reset_n low, async): FSM to IDLE, wait counter 0, readdata 0, bus_error 0. Memory array is not cleared. A transaction in progress is aborted; no write is committed.
- req = read | write. FSM states:
  - IDLE: on req with WAIT_STATES>0, go to STALL, cnt=1.
  - STALL: cnt increments each cycle; when cnt==WAIT_STATES, go to ACCESS.
  - ACCESS: accept on this edge, then return to IDLE.
  - If req drops in STALL, return to IDLE with cnt=0 and no access.
- waitrequest = req && !(state==ACCESS || (state==IDLE && WAIT_STATES==0)). It is combinational from state and req, and is 0 when there is no req.
- Acceptance edge is the rising edge where req && !waitrequest.
  - With WAIT_STATES=N, waitrequest is high for exactly N cycles of a held request.
  - Back-to-back requests each incur N wait cycles.
- Index: word index = (address - BASE_ADDR) >> 2, computed in 32-bit unsigned arithmetic. In range iff index < DEPTH_WORDS.
- Read accepted:
  - readdata <= mem[index] at the acceptance edge; value holds until the next accepted read.
  - address==0: readdata <= 0, no error.
  - Out of range or address[1:0]!=0: readdata <= 0, bus_error <= 1.
- Write accepted:
  - For each i with byteenable[i]=1, mem[index] byte i <= writedata[8i+7:8i]; other bytes unchanged.
  - byteenable 4'b0000 is a no-op and not an error.
  - Out of range, address==0, or misaligned: no write, bus_error <= 1.
- read and write both high:
  - Completes the wait-state handshake normally.
  - At acceptance: no access, readdata unchanged, bus_error <= 1.
- Backdoor: init_we writes init_data to mem[init_index] on the rising edge, in any state.
  - Same edge and same word as an accepted bus write: bus-enabled bytes take the bus value, other bytes take init_data.
- bus_error is cleared only by reset.
- No read-during-write hazard: a read accepted on the edge after a write returns the new data.

Test Plan:
- WAIT_STATES=2, preload mem[1]=32'h8D090030; hold read at 0xBFC00004 → waitrequest high 2 cycles, low in 3rd; readdata=32'h8D090030 the cycle after acceptance; bus_error=0.
- WAIT_STATES=0, mem[12]=32'hBFC00018; read 0xBFC00030 → waitrequest never high; readdata=32'hBFC00018 next cycle. Then read address 0 → readdata=0, bus_error=0.
- mem[3]=32'h11223344; write 0xBFC0000C, writedata=32'hAABBCCDD, byteenable=4'b0101 → readback 32'h11BB33DD. Then byteenable=4'b0000 write → unchanged.
- DEPTH_WORDS=64: read 0xBFC00100 and write 0xBFC00102 → read returns 0; write has no effect on any word; bus_error=1 after first, stays 1.
- WAIT_STATES=3, write held; reset_n pulsed low in 2nd stall cycle → waitrequest drops immediately, target word unchanged, readdata=0, bus_error=0; a new write after release takes 3 wait cycles and commits.
- read and write both high at a valid address → after the wait states, no memory change, readdata unchanged, bus_error=1.
